ts_tick_gen: RTL and testbench
==============================

# ts_tick_gen

Parametrised multi-stage timebase for the timescale regression diags. A chain of decade-style counters turns the simulation clock into one-cycle ticks at every time unit between precision and unit (for example fs up to s). An optional timeout countdown on the top-stage tick replaces the fixed `#N; $finish` delay with a programmable, cycle-accurate `done` flag. It sits beside `main` in timescale diags and is instanced under any `timescale` directive.

## Interface
- `NUM_STAGES`, default 4: number of cascaded counter stages; must be at least 1.
- `RATIO`, default 1000: wrap value of every stage, i.e. the unit ratio between adjacent stages; must be at least 2.
- `TO_W`, default 8: width of the timeout count.
- `clock`  in  1: the only clock; all state updates on its rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `enable`  in  1: when high, stage 0 advances by one on each cycle.
- `count`  out  NUM_STAGES*CNT_W: concatenated stage counts, with stage 0 in the LSBs.
- `tick`  out  NUM_STAGES: bit k pulses high for one cycle when stage k wraps.
- `overflow`  out  1: sticky flag, set when the top stage wraps.
- `to_start`  in  1: loads `to_val` and starts the countdown (only with `TS_TICK_TIMEOUT_EN`).
- `to_val`  in  TO_W: number of top-stage ticks to wait (only with the macro).
- `done`  out  1: countdown has expired (only with the macro).

## Operation
- CNT_W = clog2(RATIO). Each stage counts from 0 to RATIO-1 and then wraps to 0; no other values are reachable.
- Carry chain:
  - carry[0] = `enable`.
  - carry[k] = carry[k-1] and (count[k-1] == RATIO-1).
  - This chain is combinational, so a full ripple across all stages completes in one edge.
- Stage k on an edge:
  - If carry[k] is high: if count[k] == RATIO-1, it loads 0 and sets tick[k] <= 1; otherwise it increments and sets tick[k] <= 0.
  - If carry[k] is low: it holds and sets tick[k] <= 0.
- `overflow` is set on the edge where the top stage wraps. It clears only on `reset`.
- Timeout state machine (with the macro):
  - States are IDLE, RUN and DONE.
  - In any state, `to_start` loads remain <= `to_val`.
    - If `to_val` == 0, the next state is DONE.
    - Otherwise the next state is RUN, even when already in RUN (restart).
  - In RUN, each edge with tick[NUM_STAGES-1] high decrements remain. When remain reaches 1 and is decremented, the next state is DONE.
  - DONE holds until `reset` or `to_start`. `done` = (state == DONE).
  - If `to_start` and the top-stage tick occur on the same edge, `to_start` wins and that tick is not counted.
- Reset mid-operation discards all counts, ticks, flags and the timeout state. No partial state survives.

## Timing
- Reset values: `count` = 0, `tick` = 0, `overflow` = 0, state = IDLE, remain = 0, `done` = 0.
- tick[0] is high in the cycle after the edge that wrapped stage 0. That is 1 cycle of latency, and it coincides with count[0] == 0.
- tick[k] first goes high RATIO^(k+1) enabled cycles after reset. All tick bits that wrap on the same edge pulse in the same cycle.
- `done` rises on the edge that consumes the final top tick. It is therefore visible the cycle after that tick pulse.
- Deasserting `enable` freezes every stage on the next edge. Ticks already registered still complete their single cycle.
- `to_start` is sampled only on clock edges. A pulse held for several cycles reloads on each of those edges.

## Configuration
- `TS_TICK_TIMEOUT_EN` defined: the `to_start`, `to_val` and `done` ports exist, and the IDLE/RUN/DONE machine is built.
- `TS_TICK_TIMEOUT_EN` undefined: those three ports and all timeout logic are absent. Counters, ticks and `overflow` behave identically.

## Structure
- Package `ts_tick_pkg`:
  - the state encoding constants TS_IDLE = 2'd0, TS_RUN = 2'd1 and TS_DONE = 2'd2;
  - a constant `clog2` function used for CNT_W.
- Sub-module `ts_tick_stage`:
  - one counter stage, parameter `RATIO`;
  - ports `clock`, `reset`, `carry_in`, `count`, `carry_out`, `tick`.
- `ts_tick_gen` instances NUM_STAGES copies of `ts_tick_stage` with a generate loop, and holds the overflow flag and the timeout machine.

## Test plan
- RATIO=10, NUM_STAGES=3, `enable` high from reset:
  - tick[0] pulses at cycles 10, 20, …;
  - tick[1] first pulses at cycle 100;
  - tick[2] and `overflow` first rise at cycle 1000, with `count` = 0 in that cycle.
- Same configuration, `enable` low for cycles 5–14: tick[0] first pulses at cycle 20, and `count` holds 5 throughout the gap.
- `reset` asserted at cycle 537 for one edge: all outputs read 0 on the next cycle, and tick[0] next pulses 10 enabled cycles later.
- With the macro, `to_val`=2 and `to_start` at cycle 0: `done` rises at cycle 2001 and stays high; a new `to_start` with `to_val`=1 drops `done` and raises it again 1000 ticks later.
- With the macro, `to_start` with `to_val`=0: `done` rises the next cycle. A restart in RUN that coincides with a top tick does not count that tick.
- Without the macro, scenario 1 gives identical `tick`, `count` and `overflow` traces, and the three timeout ports are absent.

Source files
------------

// File: rtl/ts_tick_pkg.sv
// ts_tick_pkg: shared timeout state encoding and the width helper used to
// size the stage counters of ts_tick_gen.
package ts_tick_pkg;

    // Timeout countdown states
    typedef enum logic [1:0] {
        TS_IDLE = 2'd0,
        TS_RUN  = 2'd1,
        TS_DONE = 2'd2
    } ts_state_e;

    // Bits needed to hold the values 0 .. n-1 (minimum 1 bit)
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        if (r == 0) r = 1;
        return r;
    endfunction

endpackage

// File: rtl/ts_tick_stage.sv
// ts_tick_stage: one decade-style counter of the timebase chain.
// Counts 0 .. RATIO-1 while carry_in is high. carry_out is combinational, so
// a carry ripples through the whole chain on a single edge. tick is the
// registered wrap pulse.
module ts_tick_stage
    import ts_tick_pkg::*;
#(
    parameter int RATIO = 1000,
    localparam int CNT_W = clog2(RATIO)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             carry_in,
    output logic [CNT_W-1:0] count,
    output logic             carry_out,
    output logic             tick
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(RATIO - 1);

    // This stage wraps on the current edge: it is enabled and sits at its last value
    assign carry_out = carry_in && (count == LAST);

    // Advance or wrap the count; the tick pulse records a wrap for one cycle
    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
            tick  <= 1'b0;
        end else begin
            tick <= carry_out;
            if (carry_in) begin
                count <= carry_out ? '0 : count + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/ts_tick_gen.sv
// ts_tick_gen: multi-stage timebase. NUM_STAGES cascaded counters, each
// wrapping at RATIO, produce one-cycle ticks at every time unit of the chain.
// A sticky overflow flags the first wrap of the top stage.
//
// Optional feature, macro TS_TICK_TIMEOUT_EN: adds to_start/to_val/done and
// an IDLE/RUN/DONE countdown of top-stage ticks. Without the macro those
// ports and the countdown do not exist.
module ts_tick_gen
    import ts_tick_pkg::*;
#(
    parameter int NUM_STAGES = 4,
    parameter int RATIO      = 1000,
    parameter int TO_W       = 8,
    localparam int CNT_W     = clog2(RATIO)
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        enable,
`ifdef TS_TICK_TIMEOUT_EN
    input  logic                        to_start,
    input  logic [TO_W-1:0]             to_val,
    output logic                        done,
`endif
    output logic [NUM_STAGES*CNT_W-1:0] count,
    output logic [NUM_STAGES-1:0]       tick,
    output logic                        overflow
);

    // Reject configurations the counter chain cannot represent
    if (NUM_STAGES < 1 || RATIO < 2 || TO_W < 1) begin : g_bad_params
        $error("ts_tick_gen: needs NUM_STAGES>=1, RATIO>=2, TO_W>=1");
    end

    // carry[k] enables stage k; carry[NUM_STAGES] marks a top-stage wrap
    logic [NUM_STAGES:0]                 carry;
    logic [NUM_STAGES-1:0][CNT_W-1:0]    cnt;

    assign carry[0] = enable;
    assign count    = cnt;

    for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
        ts_tick_stage #(
            .RATIO (RATIO)
        ) u_stage (
            .clock     (clock),
            .reset     (reset),
            .carry_in  (carry[k]),
            .count     (cnt[k]),
            .carry_out (carry[k+1]),
            .tick      (tick[k])
        );
    end

    // Sticky flag raised on the edge that wraps the top stage
    always_ff @(posedge clock) begin
        if (reset) overflow <= 1'b0;
        else if (carry[NUM_STAGES]) overflow <= 1'b1;
    end

`ifdef TS_TICK_TIMEOUT_EN
    ts_state_e       state;
    logic [TO_W-1:0] remain;

    // Countdown of top-stage ticks; a start always wins over a coincident tick
    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= TS_IDLE;
            remain <= '0;
            done   <= 1'b0;
        end else if (to_start) begin
            remain <= to_val;
            if (to_val == '0) begin
                state <= TS_DONE;
                done  <= 1'b1;
            end else begin
                state <= TS_RUN;
                done  <= 1'b0;
            end
        end else begin
            case (state)
                TS_RUN: begin
                    if (tick[NUM_STAGES-1]) begin
                        remain <= remain - TO_W'(1);
                        if (remain == TO_W'(1)) begin
                            state <= TS_DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_ts_tick_gen.sv
// tb_ts_tick_gen: scoreboard bench for ts_tick_gen (NUM_STAGES=3, RATIO=10).
// The model tracks the number of enabled edges since reset and derives the
// digits, ticks and overflow from it arithmetically; timeout checks are
// built only when TS_TICK_TIMEOUT_EN is defined.
module tb_ts_tick_gen;

    localparam int NS = 3;
    localparam int R  = 10;
    localparam int CW = 4;
    localparam int TW = 8;

    logic              clock;
    logic              reset;
    logic              enable;
`ifdef TS_TICK_TIMEOUT_EN
    logic              to_start;
    logic [TW-1:0]     to_val;
    logic              done;
`endif
    logic [NS*CW-1:0]  count;
    logic [NS-1:0]     tick;
    logic              overflow;

    ts_tick_gen #(
        .NUM_STAGES (NS),
        .RATIO      (R),
        .TO_W       (TW)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .enable   (enable),
`ifdef TS_TICK_TIMEOUT_EN
        .to_start (to_start),
        .to_val   (to_val),
        .done     (done),
`endif
        .count    (count),
        .tick     (tick),
        .overflow (overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [NS*CW-1:0] count;
        logic [NS-1:0]    tick;
        logic             ovf;
        logic             done;
    } exp_t;

    exp_t sb[$];

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int P[NS+1];

    // model state
    int          m_ecnt;
    logic [NS-1:0] m_tick;
    logic        m_ovf;
    int          m_state;
    int          m_rem;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    // Drive one cycle of inputs, predict the outputs after the edge, compare
    task automatic step(input logic en, input logic rst, input logic tos, input int tov);
        exp_t e;
        logic old_top;
        enable = en;
        reset  = rst;
`ifdef TS_TICK_TIMEOUT_EN
        to_start = tos;
        to_val   = TW'(tov);
`endif
        if (rst) begin
            m_ecnt = 0; m_tick = '0; m_ovf = 1'b0; m_state = 0; m_rem = 0;
        end else begin
            old_top = m_tick[NS-1];
            if (tos) begin
                m_rem   = tov;
                m_state = (tov == 0) ? 2 : 1;
            end else if (m_state == 1 && old_top) begin
                m_rem--;
                if (m_rem == 0) m_state = 2;
            end
            if (en) begin
                m_ecnt++;
                for (int k = 0; k < NS; k++) m_tick[k] = (m_ecnt % P[k+1]) == 0;
            end else begin
                m_tick = '0;
            end
            if (m_tick[NS-1]) m_ovf = 1'b1;
        end
        for (int k = 0; k < NS; k++) e.count[k*CW +: CW] = CW'((m_ecnt / P[k]) % R);
        e.tick = m_tick;
        e.ovf  = m_ovf;
        e.done = (m_state == 2);
        sb.push_back(e);

        @(posedge clock);
        #1;
        cyc++;
        if (sb.size() == 0) begin
            chk("sb_empty", 64'd1, 64'd0);
        end else begin
            e = sb.pop_front();
            chk("count", 64'(count), 64'(e.count));
            chk("tick", 64'(tick), 64'(e.tick));
            chk("overflow", 64'(overflow), 64'(e.ovf));
`ifdef TS_TICK_TIMEOUT_EN
            chk("done", 64'(done), 64'(e.done));
`endif
        end
    endtask

    task automatic do_reset();
        step(1'b0, 1'b1, 1'b0, 0);
        step(1'b0, 1'b1, 1'b0, 0);
        cyc = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int f0, f1, f2, n0;
        logic [NS*CW-1:0] c1000;
        logic o999, o1000;
`ifdef TS_TICK_TIMEOUT_EN
        int fd, budget;
`endif
        P[0] = 1;
        for (int k = 0; k < NS; k++) P[k+1] = P[k] * R;
        enable = 1'b0;
        reset  = 1'b1;
`ifdef TS_TICK_TIMEOUT_EN
        to_start = 1'b0;
        to_val   = '0;
`endif

        // Scenario 1: free run from reset to the first top wrap
        do_reset();
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_tick", 64'(tick), 64'd0);
        chk("rst_ovf", 64'(overflow), 64'd0);
        f0 = -1; f1 = -1; f2 = -1; n0 = 0; c1000 = '1; o999 = 1'bx; o1000 = 1'b0;
        for (int c = 0; c < 1001; c++) begin
            step(1'b1, 1'b0, 1'b0, 0);
            if (tick[0]) n0++;
            if (tick[0] && f0 < 0) f0 = cyc;
            if (tick[1] && f1 < 0) f1 = cyc;
            if (tick[2] && f2 < 0) f2 = cyc;
            if (cyc == 999) o999 = overflow;
            if (cyc == 1000) begin c1000 = count; o1000 = overflow; end
        end
        chk("first_t0", 64'(f0), 64'd10);
        chk("first_t1", 64'(f1), 64'd100);
        chk("first_t2", 64'(f2), 64'd1000);
        chk("t0_pulses", 64'(n0), 64'd100);
        chk("cnt_at_1000", 64'(c1000), 64'd0);
        chk("ovf_at_999", 64'(o999), 64'd0);
        chk("ovf_at_1000", 64'(o1000), 64'd1);

        // Scenario 2: enable low for cycles 5..14
        do_reset();
        f0 = -1;
        for (int c = 0; c < 30; c++) begin
            step(!(c >= 5 && c <= 14), 1'b0, 1'b0, 0);
            if (cyc >= 5 && cyc <= 15) chk("gap_hold", 64'(count), 64'd5);
            if (tick[0] && f0 < 0) f0 = cyc;
        end
        chk("gap_first_t0", 64'(f0), 64'd20);

        // Scenario 3: reset for one edge at cycle 537
        do_reset();
        for (int c = 0; c < 537; c++) step(1'b1, 1'b0, 1'b0, 0);
        step(1'b1, 1'b1, 1'b0, 0);
        chk("midrst_count", 64'(count), 64'd0);
        chk("midrst_tick", 64'(tick), 64'd0);
        chk("midrst_ovf", 64'(overflow), 64'd0);
        f0 = -1;
        for (int c = 0; c < 20; c++) begin
            step(1'b1, 1'b0, 1'b0, 0);
            if (tick[0] && f0 < 0) f0 = cyc;
        end
        chk("midrst_t0", 64'(f0), 64'd548);

`ifdef TS_TICK_TIMEOUT_EN
        // Scenario 4: timeout countdown
        do_reset();
        chk("rst_done", 64'(done), 64'd0);
        step(1'b1, 1'b0, 1'b1, 2);
        fd = -1;
        while (cyc < 2002) begin
            step(1'b1, 1'b0, 1'b0, 0);
            if (done && fd < 0) fd = cyc;
        end
        chk("done_rise", 64'(fd), 64'd2001);
        chk("done_stay", 64'(done), 64'd1);

        step(1'b1, 1'b0, 1'b1, 1);
        chk("restart_drop", 64'(done), 64'd0);
        fd = -1; budget = 1500;
        while (fd < 0 && budget > 0) begin
            step(1'b1, 1'b0, 1'b0, 0);
            if (done) fd = cyc;
            budget--;
        end
        chk("done_rise2", 64'(fd), 64'd3001);

        step(1'b1, 1'b0, 1'b1, 5);
        chk("run_val5", 64'(done), 64'd0);
        step(1'b1, 1'b0, 1'b1, 0);
        chk("zero_done", 64'(done), 64'd1);

        // Restart that coincides with a top tick must not count it
        step(1'b1, 1'b0, 1'b1, 1);
        budget = 1200;
        while (!tick[NS-1] && budget > 0) begin
            step(1'b1, 1'b0, 1'b0, 0);
            budget--;
        end
        chk("coincide_cyc", 64'(cyc), 64'd4000);
        step(1'b1, 1'b0, 1'b1, 1);
        chk("coincide_no_count", 64'(done), 64'd0);
        fd = -1; budget = 1200;
        while (fd < 0 && budget > 0) begin
            step(1'b1, 1'b0, 1'b0, 0);
            if (done) fd = cyc;
            budget--;
        end
        chk("coincide_rise", 64'(fd), 64'd5001);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
